// File: rtl/edge_ni.sv
// Mesh edge network interface: packetizes host requests into head/body/tail flits
// and unpacks ejected flits to host words. Optional EDGE_NI_STATS_EN adds packet counters.
module edge_ni #(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 4,
    parameter int MAX_LEN = 8,
    parameter int SRC_X   = 0,
    parameter int SRC_Y   = 1,
    localparam int FLIT_W = DATA_W + 2,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               host_req_valid_i,
    output logic               host_req_ready_o,
    input  logic [COORD_W-1:0] host_dest_x_i,
    input  logic [COORD_W-1:0] host_dest_y_i,
    input  logic [LEN_W-1:0]   host_len_i,
    input  logic               host_data_valid_i,
    output logic               host_data_ready_o,
    input  logic [DATA_W-1:0]  host_data_i,
    output logic               mesh_tx_valid_o,
    input  logic               mesh_tx_ready_i,
    output logic [FLIT_W-1:0]  mesh_tx_flit_o,
    input  logic               mesh_rx_valid_i,
    output logic               mesh_rx_ready_o,
    input  logic [FLIT_W-1:0]  mesh_rx_flit_i,
    output logic               host_rx_valid_o,
    input  logic               host_rx_ready_i,
    output logic [DATA_W-1:0]  host_rx_data_o,
    output logic               host_rx_last_o,
    output logic [COORD_W-1:0] host_rx_src_x_o,
    output logic [COORD_W-1:0] host_rx_src_y_o,
    output logic               rx_err_o
`ifdef EDGE_NI_STATS_EN
   ,output logic [15:0]        tx_pkt_cnt_o,
    output logic [15:0]        rx_pkt_cnt_o
`endif
);

    // state    | meaning
    // TX_IDLE  | waiting for a host packet request
    // TX_HEAD  | presenting the head (or head_tail) flit
    // TX_DATA  | passing host payload words straight to the mesh
    // RX_HEAD  | expecting a head flit from the mesh
    // RX_PAY   | passing payload flits straight to the host
    typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_DATA} tx_state_e;
    typedef enum logic {RX_HEAD, RX_PAY} rx_state_e;

    localparam logic [1:0] FT_BODY      = 2'b00;
    localparam logic [1:0] FT_HEAD      = 2'b01;
    localparam logic [1:0] FT_TAIL      = 2'b10;
    localparam logic [1:0] FT_HEAD_TAIL = 2'b11;

    tx_state_e          tx_state_q, tx_state_d;
    rx_state_e          rx_state_q, rx_state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [COORD_W-1:0] dest_x_q, dest_x_d;
    logic [COORD_W-1:0] dest_y_q, dest_y_d;
    logic [COORD_W-1:0] src_x_q, src_x_d;
    logic [COORD_W-1:0] src_y_q, src_y_d;
    logic               rx_err_q, rx_err_d;
    logic               en_q;
    logic [DATA_W-1:0]  head_payload;
    logic [LEN_W-1:0]   len_sat;
    logic [1:0]         rx_type;

    // en_q keeps the idle-state readies low while reset is asserted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= TX_IDLE;
            rem_q      <= '0;
            dest_x_q   <= '0;
            dest_y_q   <= '0;
            en_q       <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rem_q      <= rem_d;
            dest_x_q   <= dest_x_d;
            dest_y_q   <= dest_y_d;
            en_q       <= 1'b1;
        end
    end

    always_comb begin
        head_payload = '0;
        head_payload[COORD_W-1:0]           = dest_x_q;
        head_payload[2*COORD_W-1:COORD_W]   = dest_y_q;
        head_payload[3*COORD_W-1:2*COORD_W] = COORD_W'(SRC_X);
        head_payload[4*COORD_W-1:3*COORD_W] = COORD_W'(SRC_Y);
    end

    assign len_sat = (host_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : host_len_i;

    always_comb begin
        tx_state_d        = tx_state_q;
        rem_d             = rem_q;
        dest_x_d          = dest_x_q;
        dest_y_d          = dest_y_q;
        host_req_ready_o  = 1'b0;
        host_data_ready_o = 1'b0;
        mesh_tx_valid_o   = 1'b0;
        mesh_tx_flit_o    = {FT_HEAD, head_payload};
        unique case (tx_state_q)
            TX_IDLE: begin
                host_req_ready_o = en_q;
                if (host_req_valid_i && en_q) begin
                    dest_x_d   = host_dest_x_i;
                    dest_y_d   = host_dest_y_i;
                    rem_d      = len_sat;
                    tx_state_d = TX_HEAD;
                end
            end
            TX_HEAD: begin
                mesh_tx_valid_o = 1'b1;
                mesh_tx_flit_o  = {(rem_q == '0) ? FT_HEAD_TAIL : FT_HEAD, head_payload};
                if (mesh_tx_ready_i) begin
                    tx_state_d = (rem_q == '0) ? TX_IDLE : TX_DATA;
                end
            end
            TX_DATA: begin
                mesh_tx_valid_o   = host_data_valid_i;
                host_data_ready_o = mesh_tx_ready_i;
                mesh_tx_flit_o    = {(rem_q == LEN_W'(1)) ? FT_TAIL : FT_BODY, host_data_i};
                if (host_data_valid_i && mesh_tx_ready_i) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state_q <= RX_HEAD;
            src_x_q    <= '0;
            src_y_q    <= '0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            src_x_q    <= src_x_d;
            src_y_q    <= src_y_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign rx_type = mesh_rx_flit_i[FLIT_W-1 -: 2];

    // A head-type flit is always consumed as a head; inside a packet it truncates it.
    always_comb begin
        rx_state_d      = rx_state_q;
        src_x_d         = src_x_q;
        src_y_d         = src_y_q;
        rx_err_d        = rx_err_q;
        mesh_rx_ready_o = 1'b0;
        host_rx_valid_o = 1'b0;
        host_rx_last_o  = 1'b0;
        unique case (rx_state_q)
            RX_HEAD: begin
                mesh_rx_ready_o = en_q;
                if (mesh_rx_valid_i && en_q) begin
                    if (rx_type[0]) begin
                        src_x_d = mesh_rx_flit_i[3*COORD_W-1:2*COORD_W];
                        src_y_d = mesh_rx_flit_i[4*COORD_W-1:3*COORD_W];
                        if (rx_type == FT_HEAD) begin
                            rx_state_d = RX_PAY;
                        end
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end
            end
            RX_PAY: begin
                if (rx_type[0]) begin
                    mesh_rx_ready_o = 1'b1;
                    if (mesh_rx_valid_i) begin
                        rx_err_d = 1'b1;
                        src_x_d  = mesh_rx_flit_i[3*COORD_W-1:2*COORD_W];
                        src_y_d  = mesh_rx_flit_i[4*COORD_W-1:3*COORD_W];
                        if (rx_type == FT_HEAD_TAIL) begin
                            rx_state_d = RX_HEAD;
                        end
                    end
                end else begin
                    host_rx_valid_o = mesh_rx_valid_i;
                    mesh_rx_ready_o = host_rx_ready_i;
                    host_rx_last_o  = (rx_type == FT_TAIL);
                    if (mesh_rx_valid_i && host_rx_ready_i && (rx_type == FT_TAIL)) begin
                        rx_state_d = RX_HEAD;
                    end
                end
            end
            default: rx_state_d = RX_HEAD;
        endcase
    end

    assign host_rx_data_o  = mesh_rx_flit_i[DATA_W-1:0];
    assign host_rx_src_x_o = src_x_q;
    assign host_rx_src_y_o = src_y_q;
    assign rx_err_o        = rx_err_q;

`ifdef EDGE_NI_STATS_EN
    logic [15:0] tx_pkt_cnt_q, rx_pkt_cnt_q;
    logic        tx_pkt_done, rx_pkt_done;

    assign tx_pkt_done = mesh_tx_valid_o && mesh_tx_ready_i && mesh_tx_flit_o[FLIT_W-1];
    assign rx_pkt_done = mesh_rx_valid_i && mesh_rx_ready_o && rx_type[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_pkt_cnt_q <= '0;
            rx_pkt_cnt_q <= '0;
        end else begin
            if (tx_pkt_done) tx_pkt_cnt_q <= tx_pkt_cnt_q + 16'd1;
            if (rx_pkt_done) rx_pkt_cnt_q <= rx_pkt_cnt_q + 16'd1;
        end
    end

    assign tx_pkt_cnt_o = tx_pkt_cnt_q;
    assign rx_pkt_cnt_o = rx_pkt_cnt_q;
`endif

endmodule

// File: tb/tb_edge_ni.sv
// Directed bench for edge_ni: expected flits/words go into queues as stimulus is
// driven and are popped by negedge monitors on each handshake.
module tb_edge_ni;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int ML = 8;
    localparam int SX = 1;
    localparam int SY = 0;
    localparam int FW = DW + 2;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          host_req_valid = 1'b0;
    logic          host_req_ready;
    logic [CW-1:0] host_dest_x = '0;
    logic [CW-1:0] host_dest_y = '0;
    logic [LW-1:0] host_len = '0;
    logic          host_data_valid = 1'b0;
    logic          host_data_ready;
    logic [DW-1:0] host_data = '0;
    logic          mesh_tx_valid;
    logic          mesh_tx_ready = 1'b0;
    logic [FW-1:0] mesh_tx_flit;
    logic          mesh_rx_valid = 1'b0;
    logic          mesh_rx_ready;
    logic [FW-1:0] mesh_rx_flit = '0;
    logic          host_rx_valid;
    logic          host_rx_ready = 1'b0;
    logic [DW-1:0] host_rx_data;
    logic          host_rx_last;
    logic [CW-1:0] host_rx_src_x;
    logic [CW-1:0] host_rx_src_y;
    logic          rx_err;
`ifdef EDGE_NI_STATS_EN
    logic [15:0]   tx_pkt_cnt;
    logic [15:0]   rx_pkt_cnt;
`endif

    edge_ni #(.DATA_W(DW), .COORD_W(CW), .MAX_LEN(ML), .SRC_X(SX), .SRC_Y(SY)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_valid_i(host_req_valid), .host_req_ready_o(host_req_ready),
        .host_dest_x_i(host_dest_x), .host_dest_y_i(host_dest_y), .host_len_i(host_len),
        .host_data_valid_i(host_data_valid), .host_data_ready_o(host_data_ready),
        .host_data_i(host_data),
        .mesh_tx_valid_o(mesh_tx_valid), .mesh_tx_ready_i(mesh_tx_ready),
        .mesh_tx_flit_o(mesh_tx_flit),
        .mesh_rx_valid_i(mesh_rx_valid), .mesh_rx_ready_o(mesh_rx_ready),
        .mesh_rx_flit_i(mesh_rx_flit),
        .host_rx_valid_o(host_rx_valid), .host_rx_ready_i(host_rx_ready),
        .host_rx_data_o(host_rx_data), .host_rx_last_o(host_rx_last),
        .host_rx_src_x_o(host_rx_src_x), .host_rx_src_y_o(host_rx_src_y),
        .rx_err_o(rx_err)
`ifdef EDGE_NI_STATS_EN
       ,.tx_pkt_cnt_o(tx_pkt_cnt), .rx_pkt_cnt_o(rx_pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [FW-1:0] txq[$];
    logic [DW:0]   rxq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] head_flit(input logic [1:0] t, input int dx, input int dy,
                                                 input int sx, input int sy);
        logic [DW-1:0] p;
        p = DW'(dx) | (DW'(dy) << 4) | (DW'(sx) << 8) | (DW'(sy) << 12);
        return {t, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [FW-1:0] ef;
        logic [DW:0]   ew;
        if (mesh_tx_valid && mesh_tx_ready) begin
            chk("tx_flit_expected", 64'(txq.size() != 0), 64'(1));
            if (txq.size() != 0) begin
                ef = txq.pop_front();
                chk("tx_flit", 64'(mesh_tx_flit), 64'(ef));
            end
        end
        if (host_rx_valid && host_rx_ready) begin
            chk("rx_beat_expected", 64'(rxq.size() != 0), 64'(1));
            if (rxq.size() != 0) begin
                ew = rxq.pop_front();
                chk("rx_beat", 64'({host_rx_last, host_rx_data}), 64'(ew));
            end
        end
    end

    initial begin
        // reset values
        #1;
        chk("rst_req_ready", 64'(host_req_ready), 64'(0));
        chk("rst_rx_ready", 64'(mesh_rx_ready), 64'(0));
        chk("rst_tx_valid", 64'(mesh_tx_valid), 64'(0));
        chk("rst_host_rx_valid", 64'(host_rx_valid), 64'(0));
        chk("rst_rx_err", 64'(rx_err), 64'(0));
        chk("rst_src", 64'({host_rx_src_x, host_rx_src_y}), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("idle_req_ready", 64'(host_req_ready), 64'(1));
        chk("idle_rx_ready", 64'(mesh_rx_ready), 64'(1));

        // 1: len=2 packet, ready mesh
        mesh_tx_ready = 1'b1;
        host_dest_x = 4'd2; host_dest_y = 4'd3; host_len = 4'd2; host_req_valid = 1'b1;
        txq.push_back(head_flit(2'b01, 2, 3, SX, SY));
        txq.push_back({2'b00, 32'hA});
        txq.push_back({2'b10, 32'hB});
        tick();
        host_req_valid = 1'b0; host_data_valid = 1'b1; host_data = 32'hA;
        #1;
        chk("t1_head_flit", 64'(mesh_tx_flit), 64'({2'b01, 32'h0000_0132}));
        chk("t1_no_data_in_head", 64'(host_data_ready), 64'(0));
        tick();
        chk("t1_body_valid", 64'(mesh_tx_valid), 64'(1));
        tick();
        host_data = 32'hB;
        #1;
        chk("t1_tail_type", 64'(mesh_tx_flit[FW-1 -: 2]), 64'(2'b10));
        tick();
        host_data_valid = 1'b0;
        #1;
        chk("t1_req_ready_after", 64'(host_req_ready), 64'(1));
        chk("t1_tx_valid_after", 64'(mesh_tx_valid), 64'(0));

        // 2: zero-length packet
        host_dest_x = 4'd4; host_dest_y = 4'd5; host_len = 4'd0; host_req_valid = 1'b1;
        txq.push_back(head_flit(2'b11, 4, 5, SX, SY));
        tick();
        host_req_valid = 1'b0;
        #1;
        chk("t2_ht_valid", 64'(mesh_tx_valid), 64'(1));
        chk("t2_data_ready_head", 64'(host_data_ready), 64'(0));
        tick();
        chk("t2_data_ready_idle", 64'(host_data_ready), 64'(0));
        chk("t2_req_ready", 64'(host_req_ready), 64'(1));
`ifdef EDGE_NI_STATS_EN
        chk("t2_tx_cnt", 64'(tx_pkt_cnt), 64'(2));
`endif

        // 3: mesh stalls the head for 5 cycles
        mesh_tx_ready = 1'b0;
        host_dest_x = 4'd5; host_dest_y = 4'd6; host_len = 4'd1; host_req_valid = 1'b1;
        tick();
        host_req_valid = 1'b0; host_data_valid = 1'b1; host_data = 32'hC;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_valid", 64'(mesh_tx_valid), 64'(1));
            chk("t3_stall_flit", 64'(mesh_tx_flit), 64'(head_flit(2'b01, 5, 6, SX, SY)));
            chk("t3_stall_no_data", 64'(host_data_ready), 64'(0));
            tick();
        end
        txq.push_back(head_flit(2'b01, 5, 6, SX, SY));
        txq.push_back({2'b10, 32'hC});
        mesh_tx_ready = 1'b1;
        tick();
        tick();
        host_data_valid = 1'b0;
        #1;
        chk("t3_req_ready", 64'(host_req_ready), 64'(1));

        // length above MAX_LEN saturates to MAX_LEN payload flits
        host_dest_x = 4'd7; host_dest_y = 4'd7; host_len = 4'd12; host_req_valid = 1'b1;
        txq.push_back(head_flit(2'b01, 7, 7, SX, SY));
        for (int i = 0; i < ML - 1; i++) txq.push_back({2'b00, 32'h100 + 32'(i)});
        txq.push_back({2'b10, 32'h100 + 32'(ML - 1)});
        tick();
        host_req_valid = 1'b0;
        tick();
        host_data_valid = 1'b1;
        for (int i = 0; i < ML; i++) begin
            host_data = 32'h100 + 32'(i);
            tick();
        end
        host_data_valid = 1'b0;
        #1;
        chk("sat_req_ready", 64'(host_req_ready), 64'(1));
`ifdef EDGE_NI_STATS_EN
        chk("sat_tx_cnt", 64'(tx_pkt_cnt), 64'(4));
`endif

        // 4: RX packet with host backpressure
        host_rx_ready = 1'b0;
        mesh_rx_flit = head_flit(2'b01, 0, 1, 1, 1); mesh_rx_valid = 1'b1;
        tick();
        chk("t4_src", 64'({host_rx_src_x, host_rx_src_y}), 64'({4'd1, 4'd1}));
        mesh_rx_flit = {2'b00, 32'h5};
        rxq.push_back({1'b0, 32'h5});
        #1;
        chk("t4_body_valid", 64'(host_rx_valid), 64'(1));
        chk("t4_body_stall_ready", 64'(mesh_rx_ready), 64'(0));
        tick();
        host_rx_ready = 1'b1;
        #1;
        chk("t4_body_stable", 64'({host_rx_last, host_rx_data}), 64'({1'b0, 32'h5}));
        tick();
        mesh_rx_flit = {2'b10, 32'h6}; host_rx_ready = 1'b0;
        rxq.push_back({1'b1, 32'h6});
        tick();
        host_rx_ready = 1'b1;
        #1;
        chk("t4_tail_last", 64'(host_rx_last), 64'(1));
        tick();
        mesh_rx_valid = 1'b0;
        #1;
        chk("t4_rx_err", 64'(rx_err), 64'(0));
        chk("t4_src_hold", 64'({host_rx_src_x, host_rx_src_y}), 64'({4'd1, 4'd1}));

        // 5: stray BODY, then a HEAD truncating an open packet
        mesh_rx_flit = {2'b00, 32'h77}; mesh_rx_valid = 1'b1;
        #1;
        chk("t5_drop_no_beat", 64'(host_rx_valid), 64'(0));
        chk("t5_drop_ready", 64'(mesh_rx_ready), 64'(1));
        tick();
        chk("t5_err_set", 64'(rx_err), 64'(1));
        mesh_rx_flit = head_flit(2'b01, 0, 0, 3, 4);
        tick();
        mesh_rx_flit = head_flit(2'b01, 0, 0, 7, 2);
        #1;
        chk("t5_head_in_pay_no_beat", 64'(host_rx_valid), 64'(0));
        chk("t5_head_in_pay_ready", 64'(mesh_rx_ready), 64'(1));
        tick();
        chk("t5_new_src", 64'({host_rx_src_x, host_rx_src_y}), 64'({4'd7, 4'd2}));
        mesh_rx_flit = {2'b10, 32'h9};
        rxq.push_back({1'b1, 32'h9});
        tick();
        mesh_rx_flit = head_flit(2'b11, 0, 0, 5, 3);
        #1;
        chk("t5_ht_no_beat", 64'(host_rx_valid), 64'(0));
        tick();
        mesh_rx_valid = 1'b0;
        #1;
        chk("t5_ht_src", 64'({host_rx_src_x, host_rx_src_y}), 64'({4'd5, 4'd3}));
        chk("t5_err_sticky", 64'(rx_err), 64'(1));
`ifdef EDGE_NI_STATS_EN
        chk("t5_rx_cnt", 64'(rx_pkt_cnt), 64'(3));
`endif

        // 6: reset in the middle of TX_DATA with rem=3
        host_dest_x = 4'd1; host_dest_y = 4'd2; host_len = 4'd3; host_req_valid = 1'b1;
        txq.push_back(head_flit(2'b01, 1, 2, SX, SY));
        tick();
        host_req_valid = 1'b0;
        tick();
        host_data_valid = 1'b1; host_data = 32'hD;
        #1;
        chk("t6_body_type", 64'(mesh_tx_flit[FW-1 -: 2]), 64'(2'b00));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tx_valid", 64'(mesh_tx_valid), 64'(0));
        chk("t6_rst_data_ready", 64'(host_data_ready), 64'(0));
        chk("t6_rst_req_ready", 64'(host_req_ready), 64'(0));
        chk("t6_rst_rx_ready", 64'(mesh_rx_ready), 64'(0));
        chk("t6_rst_err", 64'(rx_err), 64'(0));
        tick();
        tick();
        host_data_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("t6_req_ready", 64'(host_req_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_tail", 64'(mesh_tx_valid), 64'(0));
            tick();
        end
`ifdef EDGE_NI_STATS_EN
        chk("t6_cnt_reset", 64'({tx_pkt_cnt, rx_pkt_cnt}), 64'(0));
`endif

        chk("tx_queue_drained", 64'(txq.size()), 64'(0));
        chk("rx_queue_drained", 64'(rxq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
